// File: rtl/db_qp_ram_ctrl_pkg.sv
// Shared definitions for the deblocking top-QP line-buffer controller:
// FSM encoding, QP word field offsets and the default clear word.
package db_qp_ram_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int QP_TOP_LSB  = 0;
  localparam int QP_MOD_LSB  = 6;
  localparam int QP_FLAG_LSB = 12;
  localparam int QP_WORD_W   = 20;

  localparam logic [QP_WORD_W-1:0] CLR_VALUE_DEF = 20'h0;

  function automatic logic [QP_WORD_W-1:0] qp_pack(input logic [5:0] qp_top,
                                                   input logic [5:0] qp_mod,
                                                   input logic [7:0] qp_flag);
    qp_pack = {qp_flag, qp_mod, qp_top};
  endfunction

endpackage

// File: rtl/db_qp_ram_ctrl_arb.sv
// Read/write arbiter for the QP line buffer: read wins unless the write
// has been starved for WR_STARVE_MAX cycles or no read is pending.
module db_qp_ram_arb #(
  parameter int WR_STARVE_MAX = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en_i,
  input  logic idle_i,
  input  logic rd_req_i,
  input  logic wr_req_i,
  output logic rd_gnt_o,
  output logic wr_gnt_o
);

  localparam int AGE_W = (WR_STARVE_MAX < 1) ? 1 : $clog2(WR_STARVE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WR_STARVE_MAX);

  logic [AGE_W-1:0] wr_age_q, wr_age_d;
  logic             wr_win;

  assign wr_win   = wr_req_i && (!rd_req_i || (wr_age_q >= AGE_MAX));
  assign wr_gnt_o = arb_en_i && wr_win;
  assign rd_gnt_o = arb_en_i && rd_req_i && !wr_win;

  // Age saturates at the threshold; any value beyond it behaves identically.
  always_comb begin
    wr_age_d = wr_age_q;
    if (wr_gnt_o)
      wr_age_d = '0;
    else if (idle_i && wr_req_i && (wr_age_q != AGE_MAX))
      wr_age_d = wr_age_q + AGE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wr_age_q <= '0;
    else        wr_age_q <= wr_age_d;
  end

endmodule

// File: rtl/db_qp_ram_ctrl.sv
// Top-QP line-buffer controller: arbitrates reads/writes to a single-port RAM
// and sequences the frame-start clear. Stall counters under DB_QP_CTRL_STAT_EN.
module db_qp_ram_ctrl
  import db_qp_ram_ctrl_pkg::*;
#(
  parameter int                    WORD_WIDTH    = 20,
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    WR_STARVE_MAX = 2,
  parameter logic [WORD_WIDTH-1:0] CLR_VALUE     = WORD_WIDTH'(CLR_VALUE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start_i,
  input  logic [ADDR_WIDTH:0]   clr_len_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_vld_o,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  output logic                  wr_gnt_o,
  output logic                  ram_cen_o,
  output logic                  ram_oen_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_data_o,
  input  logic [WORD_WIDTH-1:0] ram_data_i,
  output logic [15:0]           rd_stall_cnt_o,
  output logic [15:0]           wr_stall_cnt_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_WIDTH;

  state_e        state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [CW-1:0] clr_tgt_q, clr_tgt_d;
  logic          clr_wr, clr_last;
  logic          arb_en;
  logic          rd_vld_q, oen_q;

  // Clear FSM. Done is raised alongside the final write so a clear of N
  // entries occupies exactly N busy cycles; a zero-length clear takes one.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_tgt_d = clr_tgt_q;
    clr_wr    = 1'b0;
    clr_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start_i) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          clr_tgt_d = (clr_len_i > DEPTH) ? DEPTH : clr_len_i;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q != clr_tgt_q) begin
          clr_wr    = 1'b1;
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
        if ((clr_cnt_q == clr_tgt_q) || (clr_cnt_q + CW'(1) == clr_tgt_q)) begin
          clr_last = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      clr_tgt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      clr_tgt_q <= clr_tgt_d;
    end
  end

  assign clr_busy_o = rst_n && (state_q == ST_CLEAR);
  assign clr_done_o = rst_n && clr_last;

  // No grants in CLEAR, in the start cycle, or while reset is held.
  assign arb_en = rst_n && (state_q == ST_IDLE) && !clr_start_i;

  db_qp_ram_arb #(
    .WR_STARVE_MAX (WR_STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en_i (arb_en),
    .idle_i   (state_q == ST_IDLE),
    .rd_req_i (rd_req_i),
    .wr_req_i (wr_req_i),
    .rd_gnt_o (rd_gnt_o),
    .wr_gnt_o (wr_gnt_o)
  );

  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (rd_gnt_o) begin
      ram_cen_o  = 1'b0;
      ram_addr_o = rd_addr_i;
    end else if (wr_gnt_o) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = wr_addr_i;
      ram_data_o = wr_data_i;
    end else if (rst_n && clr_wr) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = clr_cnt_q[ADDR_WIDTH-1:0];
      ram_data_o = CLR_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      oen_q    <= 1'b1;
    end else begin
      rd_vld_q <= rd_gnt_o;
      oen_q    <= ~rd_gnt_o;
    end
  end

  assign rd_vld_o  = rd_vld_q;
  assign ram_oen_o = oen_q;
  assign rd_data_o = rd_vld_q ? ram_data_i : '0;

`ifdef DB_QP_CTRL_STAT_EN
  logic [15:0] rd_stall_q, wr_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      if (rd_req_i && !rd_gnt_o && (rd_stall_q != 16'hFFFF)) rd_stall_q <= rd_stall_q + 16'd1;
      if (wr_req_i && !wr_gnt_o && (wr_stall_q != 16'hFFFF)) wr_stall_q <= wr_stall_q + 16'd1;
    end
  end

  assign rd_stall_cnt_o = rd_stall_q;
  assign wr_stall_cnt_o = wr_stall_q;
`else
  assign rd_stall_cnt_o = '0;
  assign wr_stall_cnt_o = '0;
`endif

endmodule
